event_serializer: RTL and testbench
===================================

# event_serializer

Downstream stage of the event filter: captures each filtered event (2-bit x, y, polarity, timestamp fields) into a small FIFO and transmits it off-chip as a UART-style serial frame on one output pin. Events that arrive while the FIFO is full are dropped. An optional counter reports how many events were dropped.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO depth in events. Must be a power of two and at least 2.
- `BAUD_DIV`, default 4: clock cycles per serial bit. Must be at least 1.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `ev_valid`, input, 1: an event is present this cycle. There is no back-pressure.
- `ev_x`, input, 2: event x coordinate.
- `ev_y`, input, 2: event y coordinate.
- `ev_p`, input, 2: event polarity.
- `ev_t`, input, 2: event timestamp.
- `tx`, output, 1: serial line. Idles high.
- `busy`, output, 1: high whenever the transmit FSM is not in IDLE.
- `fifo_level`, output, $clog2(DEPTH)+1: number of stored events.
- `drop_count`, output, 8: dropped-event count. Saturating.

## Operation

- Event word: `{ev_x, ev_y, ev_p, ev_t}`, with `ev_x` in bits 7:6 and `ev_t` in bits 1:0.
- FIFO write:
  - Occurs on the edge ending any cycle where `ev_valid` = 1 and the event is accepted.
  - An event is accepted if `fifo_level` < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the event is dropped, and the FIFO contents are unchanged.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop leaves `fifo_level` unchanged.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx` = 1. If `fifo_level` > 0, pop the head word into the shift register and go to START.
  - START: `tx` = 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for BAUD_DIV cycles. A 3-bit bit index and a baud counter of width $clog2(BAUD_DIV)+1 track position. After bit 7, go to STOP.
  - STOP: `tx` = 1 for BAUD_DIV cycles, then go to IDLE.
- A frame is 10 × BAUD_DIV cycles. Consecutive frames are separated by exactly one IDLE cycle with `tx` high.
- `tx`, `busy` and `fifo_level` are registered outputs.

## Timing

- Reset values: `tx` = 1, `busy` = 0, `fifo_level` = 0, `drop_count` = 0. FSM goes to IDLE and both FIFO pointers go to 0.
- Reset asserted mid-frame:
  - `tx` is high in the cycle after the reset edge.
  - The partial frame is abandoned.
  - All queued events are discarded.
  - `ev_valid` is ignored during reset.
- Latency, with `ev_valid` high in cycle k and the FIFO empty and idle:
  - `fifo_level` = 1 in cycle k+1.
  - Pop happens at the end of cycle k+1.
  - Start bit occupies cycles k+2 .. k+1+BAUD_DIV.
  - `busy` rises in cycle k+2.
- `busy` falls in the IDLE cycle following the last STOP cycle.
- Full FIFO with a pop in the same cycle as `ev_valid`: the event is accepted.

## Configuration

- `EVENT_SER_DROPCNT_EN` defined:
  - `drop_count` increments by 1 on each dropped event.
  - It saturates at 255 and clears only on `rst`.
- `EVENT_SER_DROPCNT_EN` not defined:
  - No counter logic is built.
  - `drop_count` is constant 0.
  - Drop behaviour is otherwise identical.

## Test plan

1. Assert `rst` for 2 cycles, then release. Required: `tx` = 1, `busy` = 0, `fifo_level` = 0, `drop_count` = 0, and `tx` stays high for 50 cycles with `ev_valid` = 0.
2. BAUD_DIV = 4. Single event x=2, y=1, p=3, t=0 (word 0x9C) in cycle k. Required:
   - `tx` = 0 for cycles k+2 .. k+5.
   - Data bits 0,0,1,1,1,0,0,1, each held 4 cycles.
   - Stop bit high for 4 cycles.
   - `busy` low in cycle k+42.
3. DEPTH = 4, with the macro defined. Six events with `ev_valid` held high in cycles 0..5. Required:
   - `fifo_level` reaches 4 after cycle 4.
   - The event in cycle 5 is dropped, and `drop_count` = 1.
   - Exactly 5 frames go out, in input order, with a single 1-cycle high gap between frames.
4. Macro defined. Drive `ev_valid` continuously for 300 cycles while the FIFO is full. Required: `drop_count` saturates at 255 and stays there.
5. Reset pulse during DATA bit 3 of a frame, with 2 events queued. Required: in the next cycle `tx` = 1, `busy` = 0 and `fifo_level` = 0, and no further frames are emitted.
6. Macro not defined: repeat scenario 3. Required: identical `tx` waveform, and `drop_count` = 0 throughout.

Source files
------------

// File: rtl/event_serializer.sv
// Event FIFO plus UART-style serializer: 8-bit event words, LSB first.
// Optional saturating drop counter: define EVENT_SER_DROPCNT_EN.
module event_serializer #(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  input  logic [1:0]                 ev_x,
  input  logic [1:0]                 ev_y,
  input  logic [1:0]                 ev_p,
  input  logic [1:0]                 ev_t,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BAUD_DIV) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          busy_q;

  logic [7:0]    word;
  logic          pop;
  logic          push;
  logic          baud_end;

  assign word     = {ev_x, ev_y, ev_p, ev_t};
  assign pop      = (state_q == S_IDLE) && (level_q != '0);
  assign push     = ev_valid && ((level_q < LW'(DEPTH)) || pop);
  assign baud_end = (cnt_q == CW'(BAUD_DIV - 1));

  // Occupancy follows push/pop; both together leave it unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Event storage; contents need no reset since level guards reads.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Transmit FSM with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            sh_q    <= mem_q[rd_ptr_q];
            cnt_q   <= '0;
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (baud_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= sh_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef EVENT_SER_DROPCNT_EN
  logic [7:0] drop_q;

  // Saturating count of events refused by a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (ev_valid && !push && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_event_serializer.sv
// Randomized bench for event_serializer against a frame-level model.
// Model tracks a word queue and the position inside the current frame.
module tb_event_serializer;

  localparam int DEPTH = 4;
  localparam int B     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ev_valid;
  logic [1:0] ev_x;
  logic [1:0] ev_y;
  logic [1:0] ev_p;
  logic [1:0] ev_t;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  event_serializer #(
    .DEPTH    (DEPTH),
    .BAUD_DIV (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .ev_p       (ev_p),
    .ev_t       (ev_t),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         m_busy;
  int         m_pos;
  logic [7:0] m_word;
  int         m_drop;
  int         cyc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h want %0h",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int s;
    if (!m_busy) return 1'b1;
    s = m_pos / B;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return m_word[s-1];
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0;
    m_pos  = 0;
    m_drop = 0;
  endtask

  // Drive one cycle, check outputs of this cycle, advance the model.
  task automatic step(input bit r, input bit v, input logic [7:0] w);
    bit pop;
    bit acc;
    rst      = r;
    ev_valid = v;
    {ev_x, ev_y, ev_p, ev_t} = w;
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("drop", 32'(drop_count), 32'(m_drop));
    if (r) begin
      model_reset();
    end else begin
      pop = !m_busy && (q.size() > 0);
      acc = v && ((q.size() < DEPTH) || pop);
      if (m_busy) begin
        m_pos++;
        if (m_pos == 10 * B) m_busy = 0;
      end else if (pop) begin
        m_word = q.pop_front();
        m_busy = 1;
        m_pos  = 0;
      end
      if (acc) begin
        q.push_back(w);
      end else if (v) begin
`ifdef EVENT_SER_DROPCNT_EN
        if (m_drop < 255) m_drop++;
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  initial begin
    cyc      = 0;
    rst      = 1'b1;
    ev_valid = 1'b0;
    {ev_x, ev_y, ev_p, ev_t} = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state, line idle for 50 cycles
    idle(50);

    // single known word 0x9C
    step(0, 1, 8'h9C);
    idle(45);

    // burst of six into a depth-4 FIFO
    for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom));
    idle(6 * 10 * B + 10);

    // long saturation run
    for (int i = 0; i < 300; i++) step(0, 1, 8'($urandom));
    chk("drop_sat", 32'(drop_count), 32'(m_drop));
    idle(5 * 10 * B + 10);

    // reset while transmitting data bit 3 with events queued
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));
    for (int i = 0; i < 200; i++) begin
      if (m_busy && (m_pos / B == 4)) break;
      step(0, 0, 8'h00);
    end
    chk("reached_bit3", 32'(m_busy && (m_pos / B == 4)), 32'd1);
    step(1, 0, 8'h00);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    idle(100);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      int pv;
      pv = (i / 500) % 3;
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 99) < (pv == 0 ? 5 : pv == 1 ? 30 : 90),
           8'($urandom));
    end
    idle(6 * 10 * B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
